// File: rtl/imm_decode_pipe_if.sv
// imm_decode_pipe_if: instruction-in / immediate-out handshake bundle for
// imm_decode_pipe. master = producer/consumer side, slave = decoder side.
interface imm_decode_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [2:0]       imm_type;
  logic [TAG_W-1:0] out_tag;
  logic             illegal;

  modport master (
    output flush, in_valid, instr, in_tag, out_ready,
    input  in_ready, out_valid, imm, imm_type, out_tag, illegal
  );

  modport slave (
    input  flush, in_valid, instr, in_tag, out_ready,
    output in_ready, out_valid, imm, imm_type, out_tag, illegal
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RISC-V immediate decoder with opcode-derived type,
// sign/zero extension to XLEN (32 or 64), pass-through tag and a 2-entry
// output/skid buffer behind a valid/ready handshake.
// Optional feature: define IMM_ILLEGAL_DET_EN to flag unrecognised opcodes.
module imm_decode_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  imm_decode_pipe_if.slave  bus
);

  localparam bit IS64 = (XLEN == 64);

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_NONE = 3'b111
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  localparam entry_t ENTRY_RST = '{imm: '0, typ: IMM_NONE, tag: '0, ill: 1'b0};

  imm_type_e          dec_type;
  logic signed [31:0] dec_raw;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_ill;
  entry_t             dec_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_v_q, out_v_d;
  logic   skid_v_q, skid_v_d;
  logic   accept, drain;

  // Opcode -> immediate type, then field assembly into a signed 32-bit value.
  always_comb begin
    dec_type = IMM_NONE;
    unique case (bus.instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_type = IMM_I;
      7'b0011011: dec_type = IS64 ? IMM_I : IMM_NONE;
      7'b0100011: dec_type = IMM_S;
      7'b1100011: dec_type = IMM_B;
      7'b1101111: dec_type = IMM_J;
      7'b0110111, 7'b0010111: dec_type = IMM_U;
      7'b1110011: dec_type = bus.instr[14] ? IMM_Z : IMM_I;
      default:    dec_type = IMM_NONE;
    endcase

    dec_raw = '0;
    unique case (dec_type)
      IMM_I: dec_raw = {{20{bus.instr[31]}}, bus.instr[31:20]};
      IMM_S: dec_raw = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      IMM_B: dec_raw = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
      IMM_J: dec_raw = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                        bus.instr[20], bus.instr[30:21], 1'b0};
      IMM_U: dec_raw = {bus.instr[31:12], 12'b0};
      IMM_Z: dec_raw = {27'b0, bus.instr[19:15]};
      default: dec_raw = '0;
    endcase
  end

  // Every format fits in 32 signed bits; the size cast extends to XLEN
  // (Z is assembled non-negative, so it zero-extends).
  assign dec_imm = XLEN'(dec_raw);

`ifdef IMM_ILLEGAL_DET_EN
  // Flag opcodes outside the recognised set.
  always_comb begin
    dec_ill = 1'b1;
    unique case (bus.instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0110011:
        dec_ill = 1'b0;
      7'b0011011, 7'b0111011:
        dec_ill = !IS64;
      default: dec_ill = 1'b1;
    endcase
  end
`else
  assign dec_ill = 1'b0;
`endif

  assign dec_entry = '{imm: dec_imm, typ: dec_type, tag: bus.in_tag, ill: dec_ill};

  assign bus.in_ready = !skid_v_q;
  assign accept       = bus.in_valid && !skid_v_q;
  assign drain        = out_v_q && bus.out_ready;

  // Output/skid buffer next state. The skid entry only exists while the
  // output is full, so with skid full no input is accepted; flush overrides.
  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    if (bus.flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (drain) begin
        out_d    = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_v_q || drain) begin
        out_d   = dec_entry;
        out_v_d = 1'b1;
      end else begin
        skid_d   = dec_entry;
        skid_v_d = 1'b1;
      end
    end else if (drain) begin
      out_v_d = 1'b0;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= ENTRY_RST;
      skid_q   <= ENTRY_RST;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.imm       = out_q.imm;
  assign bus.imm_type  = out_q.typ;
  assign bus.out_tag   = out_q.tag;
  assign bus.illegal   = out_q.ill;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe: directed bench for imm_decode_pipe (XLEN=32 main DUT,
// XLEN=64 side DUT) with an in-order scoreboard on the 32-bit instance.
module tb_imm_decode_pipe;

`ifdef IMM_ILLEGAL_DET_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  imm_decode_pipe_if #(.XLEN(32), .TAG_W(32)) bus ();
  imm_decode_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  imm_decode_pipe #(.XLEN(32), .TAG_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  imm_decode_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Reference decoder built from arithmetic shifts of the sign-extended word.
  function automatic exp_t ref_decode(input logic [31:0] i, input bit is64, input logic [31:0] tag);
    exp_t e;
    logic signed [63:0] s;
    logic [63:0] v;
    s = $signed({{32{i[31]}}, i});
    v = '0;
    e.typ = 3'b111;
    e.ill = 1'b0;
    e.tag = tag;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin e.typ = 3'b000; v = s >>> 20; end
      7'h1B: if (is64) begin e.typ = 3'b000; v = s >>> 20; end else e.ill = DET;
      7'h23: begin e.typ = 3'b001; v = ((s >>> 25) << 5) | 64'(i[11:7]); end
      7'h63: begin
        e.typ = 3'b010;
        v = ((s >>> 31) << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
      end
      7'h6F: begin
        e.typ = 3'b011;
        v = ((s >>> 31) << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
      end
      7'h37, 7'h17: begin e.typ = 3'b100; v = (s >>> 12) << 12; end
      7'h73: if (i[14]) begin e.typ = 3'b101; v = 64'(i[19:15]); end
             else begin e.typ = 3'b000; v = s >>> 20; end
      7'h33: ;
      7'h3B: if (!is64) e.ill = DET;
      default: e.ill = DET;
    endcase
    e.imm = is64 ? v : {32'b0, v[31:0]};
    return e;
  endfunction

  // Scoreboard: compare the departing entry, then record any accepted input.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (bus.flush) begin
      sb.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 64'(bus.out_tag), 64'hDEAD);
        end else begin
          mon_e = sb.pop_front();
          check("sb_imm", 64'(bus.imm), mon_e.imm);
          check("sb_type", 64'(bus.imm_type), 64'(mon_e.typ));
          check("sb_tag", 64'(bus.out_tag), 64'(mon_e.tag));
          check("sb_illegal", 64'(bus.illegal), 64'(mon_e.ill));
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        sb.push_back(ref_decode(bus.instr, 1'b0, bus.in_tag));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_instr [5];
    logic [31:0] b2b_imm   [5];
    logic [2:0]  b2b_type  [5];
    logic [31:0] ill_instr [3];
    logic        ill_exp   [3];

    b2b_instr = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F, 32'h123452B7, 32'h3002D073};
    b2b_imm   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000005};
    b2b_type  = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    ill_instr = '{32'h0000007F, 32'hFFF0009B, 32'h00B50533};
    ill_exp   = '{DET, DET, 1'b0};

    bus.flush = 0; bus.in_valid = 0; bus.instr = '0; bus.in_tag = '0; bus.out_ready = 0;
    bus64.flush = 0; bus64.in_valid = 0; bus64.instr = '0; bus64.in_tag = '0; bus64.out_ready = 1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_imm", 64'(bus.imm), 64'd0);
    check("rst_imm_type", 64'(bus.imm_type), 64'd7);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // Back-to-back, one result per cycle, latency of one edge
    bus.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1; bus.instr = b2b_instr[k]; bus.in_tag = 32'(100 + k);
      @(posedge clk); #1;
      check("b2b_valid", 64'(bus.out_valid), 64'd1);
      check("b2b_imm", 64'(bus.imm), 64'(b2b_imm[k]));
      check("b2b_type", 64'(bus.imm_type), 64'(b2b_type[k]));
      check("b2b_tag", 64'(bus.out_tag), 64'(100 + k));
    end
    bus.in_valid = 0;
    @(posedge clk); #1;
    check("b2b_drained", 64'(bus.out_valid), 64'd0);

    // XLEN=64 instance
    bus64.in_valid = 1; bus64.instr = 32'h800002B7; bus64.in_tag = 32'h55;
    @(posedge clk); #1;
    check("x64_lui_imm", bus64.imm, 64'hFFFFFFFF80000000);
    check("x64_lui_type", 64'(bus64.imm_type), 64'd4);
    bus64.instr = 32'hFFF0009B;
    @(posedge clk); #1;
    check("x64_addiw_imm", bus64.imm, 64'hFFFFFFFFFFFFFFFF);
    check("x64_addiw_type", 64'(bus64.imm_type), 64'd0);
    check("x64_addiw_illegal", 64'(bus64.illegal), 64'd0);
    bus64.in_valid = 0;

    // Backpressure: two accepts then in_ready drops
    bus.out_ready = 0;
    bus.in_valid = 1; bus.instr = 32'h00100093; bus.in_tag = 200;
    @(posedge clk); #1;
    check("bp_ready_after1", 64'(bus.in_ready), 64'd1);
    bus.instr = 32'h0FF00113; bus.in_tag = 201;
    @(posedge clk); #1;
    check("bp_ready_after2", 64'(bus.in_ready), 64'd0);
    bus.instr = 32'h80000063; bus.in_tag = 202;
    @(posedge clk); #1;
    check("bp_still_blocked", 64'(bus.in_ready), 64'd0);
    check("bp_stable_tag", 64'(bus.out_tag), 64'd200);
    check("bp_stable_imm", 64'(bus.imm), 64'd1);
    bus.out_ready = 1;
    @(posedge clk); #1;
    check("bp_skid_to_out", 64'(bus.out_tag), 64'd201);
    check("bp_ready_rises", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 0;
    check("bp_third_tag", 64'(bus.out_tag), 64'd202);
    check("bp_third_imm", 64'(bus.imm), 64'hFFFFF000);
    @(posedge clk); #1;
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush with two entries buffered and in_valid high
    bus.out_ready = 0;
    bus.in_valid = 1; bus.instr = 32'h00500093; bus.in_tag = 300;
    @(posedge clk); #1;
    bus.in_tag = 301;
    @(posedge clk); #1;
    bus.in_tag = 302; bus.flush = 1;
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    check("flush2_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush2_in_ready", 64'(bus.in_ready), 64'd1);

    // Flush with one entry buffered: the simultaneous input must be dropped
    bus.in_valid = 1; bus.in_tag = 310;
    @(posedge clk); #1;
    bus.in_tag = 311; bus.flush = 1; bus.out_ready = 1;
    @(posedge clk); #1;
    bus.flush = 0; bus.in_valid = 0;
    check("flush1_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush1_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("flush_no_ghost", 64'(bus.out_valid), 64'd0);

    // Unknown / NONE opcodes
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1; bus.instr = ill_instr[k]; bus.in_tag = 32'(400 + k);
      @(posedge clk); #1;
      check("none_illegal", 64'(bus.illegal), 64'(ill_exp[k]));
      check("none_imm", 64'(bus.imm), 64'd0);
      check("none_type", 64'(bus.imm_type), 64'd7);
    end
    bus.in_valid = 0;
    @(posedge clk); #1;

    // Asynchronous reset mid-stream
    bus.out_ready = 0;
    bus.in_valid = 1; bus.instr = 32'hFFF00093; bus.in_tag = 500;
    @(posedge clk); #1;
    bus.in_valid = 0;
    check("prerst_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_imm", 64'(bus.imm), 64'd0);
    check("arst_imm_type", 64'(bus.imm_type), 64'd7);
    check("arst_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1; bus.out_ready = 1;
    @(posedge clk); #1;
    check("postrst_valid", 64'(bus.out_valid), 64'd0);
    check("sb_empty_at_end", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Pipelined immediate decoder for the RISC-V core's decode stage. Each accepted instruction word produces its immediate type, derived from the opcode, and its sign- or zero-extended immediate at XLEN width. Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so stalls do not create combinational ready paths. The block replaces the externally-selected combinational extender, adds XLEN=64, adds the CSR zimm format, and carries a pass-through tag (the PC).

## Interface
Parameters:
- XLEN, 32, result width; only 32 or 64 are legal.
- TAG_W, 32, width of the pass-through tag.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  instr/in_tag are valid.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word.
- in_tag  in  TAG_W  tag, typically the PC.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- imm  out  XLEN  extended immediate.
- imm_type  out  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 111 NONE.
- out_tag  out  TAG_W  tag of the current result.
- illegal  out  1  unrecognised opcode (see Configuration).

## Operation
- Type is decoded from instr[6:0]:
  - I: 0000011, 0010011, 1100111; also 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - J: 1101111.
  - U: 0110111, 0010111.
  - SYSTEM (1110011): instr[14]=1 gives Z, otherwise I.
  - NONE: 0110011, 0111011 (XLEN=64), and every unlisted opcode.
- Field assembly, before extension:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
  - Z: instr[19:15], zero-extended.
  - NONE: imm is all zeros.
- Extension: I, S, B, J and U sign-extend from instr[31] to XLEN. For XLEN=64, U therefore fills bits 63:32 with instr[31].
- OP-IMM shift immediates are not masked; the ALU uses the low bits.
- Buffering: one output register plus one skid register, each holding {imm, type, tag, illegal}.
  - The output register drives the out_* ports.
  - Skid register is empty: an accepted input loads the output register if it is empty or draining this cycle; otherwise it loads the skid register.
  - Output drains while the skid register is full: the skid entry moves into the output register.
- in_ready = skid register empty. It is a register-derived signal with no combinational path from out_ready.
- flush clears both valid bits. flush wins over a simultaneous accept (the input is dropped) and over a simultaneous drain.
- An entry is never duplicated or reordered.

## Timing
- Reset values: out_valid=0, in_ready=1, imm=0, imm_type=111, out_tag=0, illegal=0. Skid register empty.
- Reset takes effect immediately when asserted, mid-transfer included. Buffered entries are lost.
- Latency: input accepted at edge N appears on the outputs after edge N, i.e. visible in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- Stall: with out_ready=0, the block accepts at most 2 entries, then drops in_ready.
- After out_ready returns: the first drain moves skid to output and in_ready rises the next cycle.
- Outputs are stable while out_valid=1 and out_ready=0.
- Cycle after flush: out_valid=0, in_ready=1.

## Configuration
- Macro IMM_ILLEGAL_DET_EN.
- Defined: illegal=1 for opcodes outside the listed set; imm=0 and imm_type=NONE for those entries. The flag travels with its entry.
- Not defined: illegal is tied to 0 and no detection logic is built. Unknown opcodes still decode as NONE with imm=0.

## Test plan
- XLEN=32, out_ready=1, instr 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, imm=0xFFFFFFFF, imm_type=000.
- Back-to-back: 0xFE112E23 (sw) -> imm=0xFFFFFFFC, S. 0xFF9FF06F (jal -8) -> 0xFFFFFFF8, J. 0x123452B7 (lui) -> 0x12345000, U. 0x3002D073 (csrrwi) -> 0x00000005, Z. One result per cycle, tags in order.
- XLEN=64, instr 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000.
- Backpressure: out_ready=0 while issuing 3 valid inputs -> in_ready falls after 2 accepts. Raise out_ready -> outputs drain in order, with no loss or duplication.
- Two entries buffered, then flush with in_valid=1 on the same edge -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- With IMM_ILLEGAL_DET_EN: instr 0x0000007F -> illegal=1, imm=0, imm_type=111. Without the macro: illegal=0. Assert rst_n=0 mid-stream -> outputs take reset values immediately.
